// File: rtl/riscv_mem_arbiter.sv
// Shares one memory port between instruction fetch and load/store; one transaction in flight.
// LS wins ties until MAX_LS_STREAK consecutive LS grants have starved a waiting fetch.
module riscv_mem_arbiter #(
  parameter int AW            = 32,
  parameter int DW            = 32,
  parameter int MAX_LS_STREAK = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            if_req,
  input  logic [AW-1:0]   if_addr,
  output logic            if_gnt,
  output logic            if_rvalid,
  output logic [DW-1:0]   if_rdata,
  input  logic            ls_req,
  input  logic            ls_we,
  input  logic [AW-1:0]   ls_addr,
  input  logic [DW-1:0]   ls_wdata,
  input  logic [DW/8-1:0] ls_be,
  output logic            ls_gnt,
  output logic            ls_rvalid,
  output logic [DW-1:0]   ls_rdata,
  output logic            mem_req,
  output logic            mem_we,
  output logic [AW-1:0]   mem_addr,
  output logic [DW-1:0]   mem_wdata,
  output logic [DW/8-1:0] mem_be,
  input  logic            mem_gnt,
  input  logic            mem_rvalid,
  input  logic [DW-1:0]   mem_rdata,
  output logic            busy
);

  localparam int SW = $clog2(MAX_LS_STREAK + 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_LS_STREAK);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  state_t        state;
  logic          owner_ls;
  logic [SW-1:0] streak;
  logic          pick_ls;

  // A waiting fetch only beats LS once the LS streak has hit its limit.
  assign pick_ls = ls_req && (!if_req || (streak < STREAK_MAX));

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      owner_ls  <= 1'b0;
      streak    <= '0;
      if_gnt    <= 1'b0;
      if_rvalid <= 1'b0;
      if_rdata  <= '0;
      ls_gnt    <= 1'b0;
      ls_rvalid <= 1'b0;
      ls_rdata  <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_be    <= '0;
      busy      <= 1'b0;
    end else begin
      if_gnt    <= 1'b0;
      ls_gnt    <= 1'b0;
      if_rvalid <= 1'b0;
      ls_rvalid <= 1'b0;
      case (state)
        IDLE: begin
          if (if_req || ls_req) begin
            state    <= ISSUE;
            busy     <= 1'b1;
            mem_req  <= 1'b1;
            owner_ls <= pick_ls;
            if (pick_ls) begin
              ls_gnt    <= 1'b1;
              mem_we    <= ls_we;
              mem_addr  <= ls_addr;
              mem_wdata <= ls_wdata;
              mem_be    <= ls_be;
              if (if_req)
                streak <= (streak == STREAK_MAX) ? streak : streak + 1'b1;
              else
                streak <= '0;
            end else begin
              if_gnt    <= 1'b1;
              mem_we    <= 1'b0;
              mem_addr  <= if_addr;
              mem_wdata <= '0;
              mem_be    <= '1;
              streak    <= '0;
            end
          end
        end
        ISSUE: begin
          if (mem_gnt) begin
            mem_req <= 1'b0;
            state   <= WAIT;
          end
        end
        WAIT: begin
          // mem_we still reflects the in-flight op, so stores return zero data.
          if (mem_rvalid) begin
            state <= IDLE;
            busy  <= 1'b0;
            if (owner_ls) begin
              ls_rvalid <= 1'b1;
              ls_rdata  <= mem_we ? '0 : mem_rdata;
            end else begin
              if_rvalid <= 1'b1;
              if_rdata  <= mem_rdata;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_riscv_mem_arbiter.sv
// Directed bench for riscv_mem_arbiter: one task per scenario, zero-wait memory model
// available for multi-transaction sequences, manual memory drive for timing-critical cases.
module tb_riscv_mem_arbiter;

  localparam logic [31:0] KEY = 32'h1234_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, if_gnt, if_rvalid;
  logic [31:0] if_addr, if_rdata;
  logic        ls_req, ls_we, ls_gnt, ls_rvalid;
  logic [31:0] ls_addr, ls_wdata, ls_rdata;
  logic [3:0]  ls_be;
  logic        mem_req, mem_we, mem_gnt, mem_rvalid, busy;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_be;

  // memory side: automatic zero-wait model or manual drive from tests
  logic        auto_mem = 1'b0;
  logic        a_gnt = 1'b0, a_rvalid = 1'b0;
  logic [31:0] a_rdata = '0;
  logic        m_gnt, m_rvalid;
  logic [31:0] m_rdata;
  assign mem_gnt    = auto_mem ? a_gnt    : m_gnt;
  assign mem_rvalid = auto_mem ? a_rvalid : m_rvalid;
  assign mem_rdata  = auto_mem ? a_rdata  : m_rdata;

  int checks = 0, errors = 0;
  int cyc = 0, if_gn = 0, ls_gn = 0, if_rv = 0, ls_rv = 0, ls_rv_cyc = 0, viol = 0;
  int order[$];
  logic [31:0] gaddr[$];
  int gcyc[$];

  always #5 clk = ~clk;

  riscv_mem_arbiter #(.AW(32), .DW(32), .MAX_LS_STREAK(4)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata), .ls_be(ls_be),
    .ls_gnt(ls_gnt), .ls_rvalid(ls_rvalid), .ls_rdata(ls_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be),
    .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .busy(busy)
  );

  // monitor + zero-wait memory, evaluated mid-cycle
  initial begin : monitor
    logic        pend;
    logic [31:0] pend_data;
    pend = 1'b0;
    pend_data = '0;
    forever begin
      @(posedge clk);
      #2;
      cyc++;
      if (if_gnt) begin if_gn++; order.push_back(0); gaddr.push_back(mem_addr); gcyc.push_back(cyc); end
      if (ls_gnt) begin ls_gn++; order.push_back(1); gaddr.push_back(mem_addr); gcyc.push_back(cyc); end
      if (if_rvalid) if_rv++;
      if (ls_rvalid) begin ls_rv++; ls_rv_cyc = cyc; end
      if ((if_gnt && ls_gnt) || (if_rvalid && ls_rvalid)) viol++;
      if (auto_mem) begin
        a_rvalid = pend;
        a_rdata  = pend ? pend_data : '0;
        pend     = 1'b0;
        a_gnt    = mem_req;
        if (mem_req) begin pend = 1'b1; pend_data = mem_addr ^ KEY; end
      end else begin
        pend = 1'b0; a_gnt = 1'b0; a_rvalid = 1'b0; a_rdata = '0;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    if_req = 0; if_addr = '0; ls_req = 0; ls_we = 0; ls_addr = '0; ls_wdata = '0; ls_be = '0;
    m_gnt = 0; m_rvalid = 0; m_rdata = '0;
    repeat (3) step();
    checks++;
    if ({if_gnt, if_rvalid, ls_gnt, ls_rvalid, mem_req, mem_we, busy} !== 7'b0) begin
      errors++; $display("FAIL reset_ctl: got %b want 0", {if_gnt, if_rvalid, ls_gnt, ls_rvalid, mem_req, mem_we, busy});
    end
    checks++;
    if ({mem_addr, mem_wdata, mem_be, if_rdata, ls_rdata} !== '0) begin
      errors++; $display("FAIL reset_data: addr %h wdata %h be %h ifr %h lsr %h want all 0", mem_addr, mem_wdata, mem_be, if_rdata, ls_rdata);
    end
    rst = 1'b0;
    step();
  endtask

  task automatic test_if_fetch();
    int b_ifg = if_gn, b_ifr = if_rv, b_lsg = ls_gn, b_lsr = ls_rv;
    if_addr = 32'h4; if_req = 1;
    step();
    checks++;
    if ({if_gnt, mem_req, mem_we, busy} !== 4'b1101) begin
      errors++; $display("FAIL if_grant: gnt/req/we/busy=%b want 1101", {if_gnt, mem_req, mem_we, busy});
    end
    checks++;
    if (mem_addr !== 32'h4 || mem_be !== 4'hF || mem_wdata !== 32'h0) begin
      errors++; $display("FAIL if_memfields: addr %h be %h wdata %h want 4 F 0", mem_addr, mem_be, mem_wdata);
    end
    if_req = 0; m_gnt = 1;
    step();
    checks++;
    if (mem_req !== 1'b0 || if_gnt !== 1'b0) begin
      errors++; $display("FAIL if_after_gnt: mem_req %b if_gnt %b want 0 0", mem_req, if_gnt);
    end
    m_gnt = 0;
    step();
    m_rvalid = 1; m_rdata = 32'h0031_00B3;
    step();
    checks++;
    if (if_rvalid !== 1'b1 || if_rdata !== 32'h0031_00B3 || busy !== 1'b0) begin
      errors++; $display("FAIL if_resp: rvalid %b rdata %h busy %b want 1 003100b3 0", if_rvalid, if_rdata, busy);
    end
    m_rvalid = 0; m_rdata = '0;
    step();
    checks++;
    if (if_gn - b_ifg != 1 || if_rv - b_ifr != 1 || ls_gn != b_lsg || ls_rv != b_lsr) begin
      errors++; $display("FAIL if_pulses: ifg %0d ifr %0d lsg %0d lsr %0d want 1 1 0 0", if_gn - b_ifg, if_rv - b_ifr, ls_gn - b_lsg, ls_rv - b_lsr);
    end
  endtask

  task automatic test_simultaneous();
    int n0 = order.size();
    auto_mem = 1;
    if_addr = 32'h200; ls_addr = 32'h100; ls_we = 0; ls_be = 4'hF; if_req = 1; ls_req = 1;
    for (int i = 0; i < 40 && (if_req || ls_req); i++) begin
      step();
      if (if_gnt) if_req = 0;
      if (ls_gnt) ls_req = 0;
    end
    if_req = 0; ls_req = 0;
    repeat (6) step();
    checks++;
    if (order.size() != n0 + 2) begin
      errors++; $display("FAIL sim_count: grants %0d want 2", order.size() - n0);
    end else begin
      checks++;
      if (order[n0] != 1 || order[n0+1] != 0) begin
        errors++; $display("FAIL sim_order: %0d,%0d want 1,0 (1=LS)", order[n0], order[n0+1]);
      end
      checks++;
      if (gaddr[n0] !== 32'h100 || gaddr[n0+1] !== 32'h200) begin
        errors++; $display("FAIL sim_addr: %h,%h want 100,200", gaddr[n0], gaddr[n0+1]);
      end
      checks++;
      if (gcyc[n0+1] != ls_rv_cyc + 1) begin
        errors++; $display("FAIL sim_spacing: if_gnt cycle %0d want %0d", gcyc[n0+1], ls_rv_cyc + 1);
      end
    end
    checks++;
    if (ls_rdata !== (32'h100 ^ KEY) || if_rdata !== (32'h200 ^ KEY)) begin
      errors++; $display("FAIL sim_rdata: ls %h if %h want %h %h", ls_rdata, if_rdata, 32'h100 ^ KEY, 32'h200 ^ KEY);
    end
  endtask

  task automatic test_starvation();
    int n0 = order.size();
    int expv[10] = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};
    auto_mem = 1;
    ls_addr = 32'h300; if_addr = 32'h400; ls_we = 0; ls_be = 4'hF; if_req = 1; ls_req = 1;
    for (int i = 0; i < 100 && order.size() < n0 + 10; i++) step();
    if_req = 0; ls_req = 0;
    repeat (6) step();
    checks++;
    if (order.size() != n0 + 10) begin
      errors++; $display("FAIL starve_count: grants %0d want 10", order.size() - n0);
    end else begin
      for (int k = 0; k < 10; k++) begin
        checks++;
        if (order[n0+k] != expv[k]) begin
          errors++; $display("FAIL starve_order[%0d]: %0d want %0d (1=LS)", k, order[n0+k], expv[k]);
        end
      end
    end
  endtask

  task automatic test_store();
    int b_ifr = if_rv;
    logic got = 0;
    auto_mem = 1;
    ls_we = 1; ls_addr = 32'h20; ls_wdata = 32'hDEAD_BEEF; ls_be = 4'b0011; ls_req = 1;
    step();
    checks++;
    if (ls_gnt !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 32'h20 || mem_wdata !== 32'hDEAD_BEEF || mem_be !== 4'b0011) begin
      errors++; $display("FAIL store_issue: gnt %b we %b addr %h wdata %h be %b want 1 1 20 deadbeef 0011", ls_gnt, mem_we, mem_addr, mem_wdata, mem_be);
    end
    ls_req = 0; ls_we = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (ls_rvalid) begin got = 1; break; end
    end
    checks++;
    if (got !== 1'b1 || ls_rdata !== 32'h0) begin
      errors++; $display("FAIL store_resp: rvalid seen %b rdata %h want 1 0", got, ls_rdata);
    end
    step();
    checks++;
    if (if_rv != b_ifr) begin
      errors++; $display("FAIL store_if_silent: if_rvalid pulses %0d want 0", if_rv - b_ifr);
    end
  endtask

  task automatic test_backpressure();
    int b_lsg = ls_gn, b_lsr = ls_rv;
    auto_mem = 0; m_gnt = 0; m_rvalid = 0; m_rdata = '0;
    ls_addr = 32'h40; ls_we = 0; ls_be = 4'hF; ls_req = 1;
    step();
    ls_req = 0;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (mem_req !== 1'b1 || mem_addr !== 32'h40 || busy !== 1'b1) begin
        errors++; $display("FAIL bp_hold[%0d]: req %b addr %h busy %b want 1 40 1", i, mem_req, mem_addr, busy);
      end
      m_rvalid = (i == 1);
      m_rdata  = (i == 1) ? 32'hBAD0_BAD0 : 32'h0;
      step();
    end
    m_rvalid = 0; m_rdata = '0; m_gnt = 1;
    checks++;
    if (mem_req !== 1'b1 || ls_rvalid !== 1'b0) begin
      errors++; $display("FAIL bp_spurious: req %b ls_rvalid %b want 1 0", mem_req, ls_rvalid);
    end
    step();
    m_gnt = 0;
    checks++;
    if (mem_req !== 1'b0 || busy !== 1'b1) begin
      errors++; $display("FAIL bp_wait: req %b busy %b want 0 1", mem_req, busy);
    end
    m_rvalid = 1; m_rdata = 32'h5555_AAAA;
    step();
    checks++;
    if (ls_rvalid !== 1'b1 || ls_rdata !== 32'h5555_AAAA) begin
      errors++; $display("FAIL bp_resp: rvalid %b rdata %h want 1 5555aaaa", ls_rvalid, ls_rdata);
    end
    m_rvalid = 0; m_rdata = '0;
    step();
    checks++;
    if (ls_gn - b_lsg != 1 || ls_rv - b_lsr != 1) begin
      errors++; $display("FAIL bp_pulses: gnt %0d rvalid %0d want 1 1", ls_gn - b_lsg, ls_rv - b_lsr);
    end
  endtask

  task automatic test_reset_mid_wait();
    int b_ifr;
    logic got = 0;
    auto_mem = 0; m_gnt = 0; m_rvalid = 0; m_rdata = '0;
    if_addr = 32'h8; if_req = 1;
    step();
    if_req = 0; m_gnt = 1;
    step();
    m_gnt = 0; rst = 1;
    step();
    rst = 0;
    checks++;
    if ({if_gnt, if_rvalid, ls_gnt, ls_rvalid, mem_req, mem_we, busy} !== 7'b0 ||
        {mem_addr, mem_wdata, mem_be, if_rdata, ls_rdata} !== '0) begin
      errors++; $display("FAIL rstmid_clear: ctl %b addr %h ifr %h lsr %h want all 0",
                         {if_gnt, if_rvalid, ls_gnt, ls_rvalid, mem_req, mem_we, busy}, mem_addr, if_rdata, ls_rdata);
    end
    b_ifr = if_rv;
    m_rvalid = 1; m_rdata = 32'h77;
    step();
    m_rvalid = 0; m_rdata = '0;
    step();
    checks++;
    if (if_rv != b_ifr || busy !== 1'b0 || if_rdata !== 32'h0) begin
      errors++; $display("FAIL rstmid_late: if_rvalid pulses %0d busy %b rdata %h want 0 0 0", if_rv - b_ifr, busy, if_rdata);
    end
    auto_mem = 1;
    if_addr = 32'hC; if_req = 1;
    for (int i = 0; i < 20; i++) begin
      step();
      if (if_gnt) if_req = 0;
      if (if_rvalid) begin got = 1; break; end
    end
    if_req = 0;
    checks++;
    if (got !== 1'b1 || if_rdata !== (32'hC ^ KEY)) begin
      errors++; $display("FAIL rstmid_next: rvalid seen %b rdata %h want 1 %h", got, if_rdata, 32'hC ^ KEY);
    end
    step();
  endtask

  task automatic test_exclusive();
    checks++;
    if (viol != 0) begin
      errors++; $display("FAIL exclusive: cycles with both gnt or both rvalid %0d want 0", viol);
    end
  endtask

  initial begin
    m_gnt = 0; m_rvalid = 0; m_rdata = '0;
    test_reset();
    test_if_fetch();
    test_simultaneous();
    test_starvation();
    test_store();
    test_backpressure();
    test_reset_mid_wait();
    test_exclusive();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule
